// File: rtl/aud_pkg.sv
// Shared types and constants for the audio record/playback sequencer.
package aud_pkg;

   // Fixed state encodings; o_state exposes these to the display logic.
   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_ARM_REC    = 3'd1;
   localparam logic [2:0] ST_REC        = 3'd2;
   localparam logic [2:0] ST_REC_PAUSE  = 3'd3;
   localparam logic [2:0] ST_ARM_PLAY   = 3'd4;
   localparam logic [2:0] ST_PLAY       = 3'd5;
   localparam logic [2:0] ST_PLAY_PAUSE = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE       = ST_IDLE,
      S_ARM_REC    = ST_ARM_REC,
      S_REC        = ST_REC,
      S_REC_PAUSE  = ST_REC_PAUSE,
      S_ARM_PLAY   = ST_ARM_PLAY,
      S_PLAY       = ST_PLAY,
      S_PLAY_PAUSE = ST_PLAY_PAUSE
   } state_t;

   localparam logic [2:0] SPD_1X  = 3'd3;
   localparam logic [2:0] SPD_MAX = 3'd6;
   localparam logic [2:0] SPD_MIN = 3'd0;

   typedef struct packed {
      logic stop;
      logic pause;
      logic rec;
      logic play;
   } cmd_t;

endpackage

// File: rtl/aud_key_pri.sv
// Priority encoder of the four transport keys into a one-hot command.
module aud_key_pri
   import aud_pkg::*;
(
   input  logic rec,
   input  logic play,
   input  logic pause,
   input  logic stop,
   output cmd_t cmd
);

   always_comb begin
      cmd = '0;
      if (stop)       cmd.stop  = 1'b1;
      else if (pause) cmd.pause = 1'b1;
      else if (rec)   cmd.rec   = 1'b1;
      else if (play)  cmd.play  = 1'b1;
   end

endmodule

// File: rtl/aud_ctrl.sv
// Record/playback sequencer: key pulses to recorder/AudDSP commands, SRAM bus
// ownership, recorded end address, and playback speed/interpolation settings.
module aud_ctrl
   import aud_pkg::*;
#(
   parameter int unsigned          ADDR_W   = 20,
   parameter logic [ADDR_W-1:0]    MAX_ADDR = '1,
   parameter int unsigned          SPD_W    = 3
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_key_rec,
   input  logic              i_key_play,
   input  logic              i_key_pause,
   input  logic              i_key_stop,
   input  logic              i_spd_up,
   input  logic              i_spd_dn,
   input  logic              i_mode_tgl,
   input  logic [ADDR_W-1:0] i_rec_addr,
   input  logic [ADDR_W-1:0] i_dsp_addr,
   output logic              o_rec_start,
   output logic              o_rec_pause,
   output logic              o_rec_stop,
   output logic              o_dsp_start,
   output logic              o_dsp_pause,
   output logic              o_dsp_stop,
   output logic [SPD_W-1:0]  o_dsp_speed,
   output logic              o_dsp_interp,
   output logic              o_sram_sel,
   output logic              o_sram_we_n,
   output logic [ADDR_W-1:0] o_end_addr,
   output logic [2:0]        o_state
);

   state_t state;
   cmd_t   cmd;
   logic   rec_end;
   logic   play_end;

   aud_key_pri u_key_pri (
      .rec   (i_key_rec),
      .play  (i_key_play),
      .pause (i_key_pause),
      .stop  (i_key_stop),
      .cmd   (cmd)
   );

   // Memory-full and end-of-recording limits only apply while actively running.
   assign rec_end  = cmd.stop || (state == S_REC  && i_rec_addr == MAX_ADDR);
   assign play_end = cmd.stop || (state == S_PLAY && i_dsp_addr >= o_end_addr);
   assign o_state  = state;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= S_IDLE;
         o_rec_start <= 1'b0;
         o_rec_pause <= 1'b0;
         o_rec_stop  <= 1'b0;
         o_dsp_start <= 1'b0;
         o_dsp_pause <= 1'b0;
         o_dsp_stop  <= 1'b0;
         o_sram_sel  <= 1'b0;
         o_sram_we_n <= 1'b1;
         o_end_addr  <= '0;
      end else begin
         o_rec_start <= 1'b0;
         o_rec_pause <= 1'b0;
         o_rec_stop  <= 1'b0;
         o_dsp_start <= 1'b0;
         o_dsp_pause <= 1'b0;
         o_dsp_stop  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (cmd.rec) begin
                  state      <= S_ARM_REC;
                  o_sram_sel <= 1'b1;
               end else if (cmd.play && o_end_addr != '0) begin
                  state      <= S_ARM_PLAY;
                  o_sram_sel <= 1'b0;
               end
            end
            // Bus already switched to the recorder; write enable follows a cycle later.
            S_ARM_REC: begin
               if (cmd.stop) begin
                  state      <= S_IDLE;
                  o_sram_sel <= 1'b0;
               end else begin
                  state       <= S_REC;
                  o_rec_start <= 1'b1;
                  o_sram_we_n <= 1'b0;
               end
            end
            S_ARM_PLAY: begin
               if (cmd.stop) begin
                  state      <= S_IDLE;
                  o_sram_sel <= 1'b0;
               end else begin
                  state       <= S_PLAY;
                  o_dsp_start <= 1'b1;
               end
            end
            S_REC, S_REC_PAUSE: begin
               if (rec_end) begin
                  state       <= S_IDLE;
                  o_rec_stop  <= 1'b1;
                  o_end_addr  <= i_rec_addr;
                  o_sram_we_n <= 1'b1;
                  o_sram_sel  <= 1'b0;
               end else if (state == S_REC && cmd.pause) begin
                  state       <= S_REC_PAUSE;
                  o_rec_pause <= 1'b1;
                  o_sram_we_n <= 1'b1;
               end else if (state == S_REC_PAUSE && (cmd.pause || cmd.rec)) begin
                  state       <= S_REC;
                  o_rec_start <= 1'b1;
                  o_sram_we_n <= 1'b0;
               end
            end
            S_PLAY, S_PLAY_PAUSE: begin
               if (play_end) begin
                  state      <= S_IDLE;
                  o_dsp_stop <= 1'b1;
               end else if (state == S_PLAY && cmd.pause) begin
                  state       <= S_PLAY_PAUSE;
                  o_dsp_pause <= 1'b1;
               end else if (state == S_PLAY_PAUSE && (cmd.pause || cmd.play)) begin
                  state       <= S_PLAY;
                  o_dsp_start <= 1'b1;
               end
            end
            default: begin
               state       <= S_IDLE;
               o_sram_sel  <= 1'b0;
               o_sram_we_n <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_dsp_speed  <= SPD_W'(SPD_1X);
         o_dsp_interp <= 1'b0;
      end else begin
         if (i_spd_up && !i_spd_dn && o_dsp_speed != SPD_W'(SPD_MAX))
            o_dsp_speed <= o_dsp_speed + 1'b1;
         else if (i_spd_dn && !i_spd_up && o_dsp_speed != SPD_W'(SPD_MIN))
            o_dsp_speed <= o_dsp_speed - 1'b1;
         if (i_mode_tgl)
            o_dsp_interp <= ~o_dsp_interp;
      end
   end

endmodule

// File: tb/tb_aud_ctrl.sv
// Directed, table-driven bench for aud_ctrl plus multi-cycle corner sequences.
module tb_aud_ctrl;

   localparam logic [6:0] K_NONE  = 7'h00;
   localparam logic [6:0] K_REC   = 7'h40;
   localparam logic [6:0] K_PLAY  = 7'h20;
   localparam logic [6:0] K_PAUSE = 7'h10;
   localparam logic [6:0] K_STOP  = 7'h08;
   localparam logic [6:0] K_UP    = 7'h04;
   localparam logic [6:0] K_DN    = 7'h02;
   localparam logic [6:0] K_TGL   = 7'h01;

   // pulse order: rec_start rec_pause rec_stop dsp_start dsp_pause dsp_stop
   localparam logic [5:0] P_NONE = 6'h00;
   localparam logic [5:0] P_RS   = 6'h20;
   localparam logic [5:0] P_RP   = 6'h10;
   localparam logic [5:0] P_RX   = 6'h08;
   localparam logic [5:0] P_DS   = 6'h04;
   localparam logic [5:0] P_DP   = 6'h02;
   localparam logic [5:0] P_DX   = 6'h01;

   localparam logic [2:0] T_IDLE = 3'd0;
   localparam logic [2:0] T_AR   = 3'd1;
   localparam logic [2:0] T_REC  = 3'd2;
   localparam logic [2:0] T_RP   = 3'd3;
   localparam logic [2:0] T_AP   = 3'd4;
   localparam logic [2:0] T_PLAY = 3'd5;
   localparam logic [2:0] T_PP   = 3'd6;

   typedef struct {
      logic [6:0]  keys;
      logic [19:0] ra;
      logic [19:0] da;
      logic [34:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        key_rec = 1'b0, key_play = 1'b0, key_pause = 1'b0, key_stop = 1'b0;
   logic        spd_up = 1'b0, spd_dn = 1'b0, mode_tgl = 1'b0;
   logic [19:0] rec_addr = '0, dsp_addr = '0;
   logic        rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop;
   logic [2:0]  dsp_speed;
   logic        dsp_interp, sram_sel, sram_we_n;
   logic [19:0] end_addr;
   logic [2:0]  state;

   int unsigned checks = 0;
   int unsigned failures = 0;
   vec_t        tbl[$];

   always #5 clk = ~clk;

   aud_ctrl #(.ADDR_W(20), .MAX_ADDR(20'hFFFFF), .SPD_W(3)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_key_rec    (key_rec),
      .i_key_play   (key_play),
      .i_key_pause  (key_pause),
      .i_key_stop   (key_stop),
      .i_spd_up     (spd_up),
      .i_spd_dn     (spd_dn),
      .i_mode_tgl   (mode_tgl),
      .i_rec_addr   (rec_addr),
      .i_dsp_addr   (dsp_addr),
      .o_rec_start  (rec_start),
      .o_rec_pause  (rec_pause),
      .o_rec_stop   (rec_stop),
      .o_dsp_start  (dsp_start),
      .o_dsp_pause  (dsp_pause),
      .o_dsp_stop   (dsp_stop),
      .o_dsp_speed  (dsp_speed),
      .o_dsp_interp (dsp_interp),
      .o_sram_sel   (sram_sel),
      .o_sram_we_n  (sram_we_n),
      .o_end_addr   (end_addr),
      .o_state      (state)
   );

   function automatic logic [34:0] pk(input logic [2:0] st, input logic [5:0] pul,
                                      input logic sel, input logic we, input logic [19:0] ea,
                                      input logic [2:0] spd, input logic it);
      return {st, pul, sel, we, ea, spd, it};
   endfunction

   function automatic logic [34:0] outs();
      return {state, rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop,
              sram_sel, sram_we_n, end_addr, dsp_speed, dsp_interp};
   endfunction

   function automatic vec_t mk(input logic [6:0] k, input logic [19:0] ra, input logic [19:0] da,
                               input logic [2:0] st, input logic [5:0] pul, input logic sel,
                               input logic we, input logic [19:0] ea, input logic [2:0] spd,
                               input logic it);
      vec_t v;
      v.keys = k;
      v.ra   = ra;
      v.da   = da;
      v.exp  = pk(st, pul, sel, we, ea, spd, it);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [34:0] got, input logic [34:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got st=%0d pulses=%b sel=%b we_n=%b end=%h spd=%0d interp=%b, expected st=%0d pulses=%b sel=%b we_n=%b end=%h spd=%0d interp=%b",
                  nm, got[34:32], got[31:26], got[25], got[24], got[23:4], got[3:1], got[0],
                  exp[34:32], exp[31:26], exp[25], exp[24], exp[23:4], exp[3:1], exp[0]);
      end
   endtask

   task automatic chk1(input string nm, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", nm, got, exp);
      end
   endtask

   // Inputs are applied just after a falling edge and outputs read at the next falling edge.
   task automatic step(input logic [6:0] k, input logic [19:0] ra, input logic [19:0] da);
      {key_rec, key_play, key_pause, key_stop, spd_up, spd_dn, mode_tgl} = k;
      rec_addr = ra;
      dsp_addr = da;
      @(posedge clk);
      @(negedge clk);
      {key_rec, key_play, key_pause, key_stop, spd_up, spd_dn, mode_tgl} = K_NONE;
   endtask

   initial begin
      logic hold_ok;

      // speed/mode exercise from reset values
      tbl.push_back(mk(K_NONE, 0, 0, T_IDLE, P_NONE, 0, 1, 0, 3, 0));
      tbl.push_back(mk(K_PLAY, 0, 0, T_IDLE, P_NONE, 0, 1, 0, 3, 0));
      tbl.push_back(mk(K_UP,   0, 0, T_IDLE, P_NONE, 0, 1, 0, 4, 0));
      tbl.push_back(mk(K_UP,   0, 0, T_IDLE, P_NONE, 0, 1, 0, 5, 0));
      tbl.push_back(mk(K_UP,   0, 0, T_IDLE, P_NONE, 0, 1, 0, 6, 0));
      tbl.push_back(mk(K_UP,   0, 0, T_IDLE, P_NONE, 0, 1, 0, 6, 0));
      tbl.push_back(mk(K_UP,   0, 0, T_IDLE, P_NONE, 0, 1, 0, 6, 0));
      tbl.push_back(mk(K_UP | K_DN, 0, 0, T_IDLE, P_NONE, 0, 1, 0, 6, 0));
      tbl.push_back(mk(K_DN,   0, 0, T_IDLE, P_NONE, 0, 1, 0, 5, 0));
      tbl.push_back(mk(K_DN,   0, 0, T_IDLE, P_NONE, 0, 1, 0, 4, 0));
      tbl.push_back(mk(K_DN,   0, 0, T_IDLE, P_NONE, 0, 1, 0, 3, 0));
      tbl.push_back(mk(K_DN,   0, 0, T_IDLE, P_NONE, 0, 1, 0, 2, 0));
      tbl.push_back(mk(K_DN,   0, 0, T_IDLE, P_NONE, 0, 1, 0, 1, 0));
      tbl.push_back(mk(K_DN,   0, 0, T_IDLE, P_NONE, 0, 1, 0, 0, 0));
      tbl.push_back(mk(K_DN,   0, 0, T_IDLE, P_NONE, 0, 1, 0, 0, 0));
      tbl.push_back(mk(K_DN,   0, 0, T_IDLE, P_NONE, 0, 1, 0, 0, 0));
      tbl.push_back(mk(K_UP | K_DN, 0, 0, T_IDLE, P_NONE, 0, 1, 0, 0, 0));
      tbl.push_back(mk(K_TGL,  0, 0, T_IDLE, P_NONE, 0, 1, 0, 0, 1));
      tbl.push_back(mk(K_TGL,  0, 0, T_IDLE, P_NONE, 0, 1, 0, 0, 0));
      tbl.push_back(mk(K_TGL,  0, 0, T_IDLE, P_NONE, 0, 1, 0, 0, 1));
      tbl.push_back(mk(K_UP,   0, 0, T_IDLE, P_NONE, 0, 1, 0, 1, 1));
      // record with pause/resume, stop at 0x64
      tbl.push_back(mk(K_REC,   0,     0, T_AR,  P_NONE, 1, 1, 0, 1, 1));
      tbl.push_back(mk(K_NONE,  0,     0, T_REC, P_RS,   1, 0, 0, 1, 1));
      tbl.push_back(mk(K_PLAY,  'h10,  0, T_REC, P_NONE, 1, 0, 0, 1, 1));
      tbl.push_back(mk(K_PAUSE, 'h10,  0, T_RP,  P_RP,   1, 1, 0, 1, 1));
      tbl.push_back(mk(K_REC,   'h10,  0, T_REC, P_RS,   1, 0, 0, 1, 1));
      tbl.push_back(mk(K_PAUSE, 'h10,  0, T_RP,  P_RP,   1, 1, 0, 1, 1));
      tbl.push_back(mk(K_PAUSE, 'h10,  0, T_REC, P_RS,   1, 0, 0, 1, 1));
      tbl.push_back(mk(K_STOP,  'h64,  0, T_IDLE, P_RX,  0, 1, 'h64, 1, 1));
      // playback with pause/resume and stop+pause collision
      tbl.push_back(mk(K_PLAY,  'h64, 0,    T_AP,   P_NONE, 0, 1, 'h64, 1, 1));
      tbl.push_back(mk(K_REC,   'h64, 0,    T_PLAY, P_DS,   0, 1, 'h64, 1, 1));
      tbl.push_back(mk(K_REC,   'h64, 'h10, T_PLAY, P_NONE, 0, 1, 'h64, 1, 1));
      tbl.push_back(mk(K_PAUSE, 'h64, 'h10, T_PP,   P_DP,   0, 1, 'h64, 1, 1));
      tbl.push_back(mk(K_PLAY,  'h64, 'h10, T_PLAY, P_DS,   0, 1, 'h64, 1, 1));
      tbl.push_back(mk(K_PAUSE, 'h64, 'h10, T_PP,   P_DP,   0, 1, 'h64, 1, 1));
      tbl.push_back(mk(K_PAUSE, 'h64, 'h10, T_PLAY, P_DS,   0, 1, 'h64, 1, 1));
      tbl.push_back(mk(K_STOP | K_PAUSE, 'h64, 'h10, T_IDLE, P_DX, 0, 1, 'h64, 1, 1));
      // stop aborts ARM states; stop in IDLE is inert
      tbl.push_back(mk(K_PLAY,  'h64, 0, T_AP,   P_NONE, 0, 1, 'h64, 1, 1));
      tbl.push_back(mk(K_STOP,  'h64, 0, T_IDLE, P_NONE, 0, 1, 'h64, 1, 1));
      tbl.push_back(mk(K_REC,   'h64, 0, T_AR,   P_NONE, 1, 1, 'h64, 1, 1));
      tbl.push_back(mk(K_STOP,  'h64, 0, T_IDLE, P_NONE, 0, 1, 'h64, 1, 1));
      tbl.push_back(mk(K_STOP,  'h64, 0, T_IDLE, P_NONE, 0, 1, 'h64, 1, 1));
      // playback runs until dsp address reaches the end address
      tbl.push_back(mk(K_PLAY,  'h64, 0,    T_AP,   P_NONE, 0, 1, 'h64, 1, 1));
      tbl.push_back(mk(K_NONE,  'h64, 0,    T_PLAY, P_DS,   0, 1, 'h64, 1, 1));
      tbl.push_back(mk(K_NONE,  'h64, 'h63, T_PLAY, P_NONE, 0, 1, 'h64, 1, 1));
      tbl.push_back(mk(K_NONE,  'h64, 'h64, T_IDLE, P_DX,   0, 1, 'h64, 1, 1));
      // key priority
      tbl.push_back(mk(K_PAUSE | K_REC, 'h64, 0, T_IDLE, P_NONE, 0, 1, 'h64, 1, 1));
      tbl.push_back(mk(K_REC | K_PLAY,  'h64, 0, T_AR,   P_NONE, 1, 1, 'h64, 1, 1));
      tbl.push_back(mk(K_NONE,          'h64, 0, T_REC,  P_RS,   1, 0, 'h64, 1, 1));
      tbl.push_back(mk(K_STOP | K_PAUSE, 'h80, 0, T_IDLE, P_RX,  0, 1, 'h80, 1, 1));

      repeat (3) @(negedge clk);
      chk("reset_held", outs(), pk(T_IDLE, P_NONE, 0, 1, 0, 3, 0));
      rst = 1'b0;
      @(negedge clk);
      chk("reset_release", outs(), pk(T_IDLE, P_NONE, 0, 1, 0, 3, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].keys, tbl[i].ra, tbl[i].da);
         chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
      end

      // 100-cycle recording, bus select precedes rec_start by one cycle
      step(K_REC, 0, 0);
      chk("long_arm", outs(), pk(T_AR, P_NONE, 1, 1, 'h80, 1, 1));
      step(K_NONE, 0, 0);
      chk("long_start", outs(), pk(T_REC, P_RS, 1, 0, 'h80, 1, 1));
      hold_ok = 1'b1;
      for (int c = 1; c < 100; c++) begin
         step(K_NONE, 20'(c), 0);
         if (outs() !== pk(T_REC, P_NONE, 1, 0, 'h80, 1, 1)) hold_ok = 1'b0;
      end
      chk1("long_hold", hold_ok, 1'b1);
      step(K_STOP, 'h64, 0);
      chk("long_stop", outs(), pk(T_IDLE, P_RX, 0, 1, 'h64, 1, 1));

      // auto-stop at the last SRAM address
      step(K_REC, 0, 0);
      step(K_NONE, 0, 0);
      step(K_NONE, 'hFFFFE, 0);
      chk("full_before", outs(), pk(T_REC, P_NONE, 1, 0, 'h64, 1, 1));
      step(K_NONE, 'hFFFFF, 0);
      chk("full_stop", outs(), pk(T_IDLE, P_RX, 0, 1, 'hFFFFF, 1, 1));

      // asynchronous reset during recording
      step(K_REC, 0, 0);
      step(K_NONE, 5, 0);
      chk("pre_reset_rec", outs(), pk(T_REC, P_RS, 1, 0, 'hFFFFF, 1, 1));
      #2 rst = 1'b1;
      #1 chk("async_reset", outs(), pk(T_IDLE, P_NONE, 0, 1, 0, 3, 0));
      @(posedge clk);
      #1 chk("reset_edge", outs(), pk(T_IDLE, P_NONE, 0, 1, 0, 3, 0));
      @(negedge clk);
      rst = 1'b0;
      step(K_PLAY, 0, 0);
      chk("play_after_reset", outs(), pk(T_IDLE, P_NONE, 0, 1, 0, 3, 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
